interval_ctrl_m: RTL and testbench
==================================

INTERVAL_CTRL_M -- requirements
Module: interval_ctrl_m

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the width of the controlled loadable up-counter and of the period.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1: request to begin timing; sampled on clk rising edge.
REQ-005 SHALL have port stop, input, 1: abort the current timing run.
REQ-006 SHALL have port periodic, input, 1: mode captured at start (1 = periodic, 0 = one-shot).
REQ-007 SHALL have port period, input, WIDTH: interval N in cycles, captured at start.
REQ-008 SHALL have port count_in, input, WIDTH: current value of the external counter.
REQ-009 SHALL have port cnt_load, output, 1: load strobe to the external counter.
REQ-010 SHALL have port cnt_data, output, WIDTH: load value to the external counter.
REQ-011 SHALL have port start_ack, output, 1: combinational start acceptance.
REQ-012 SHALL have port busy, output, 1: high in the LOAD and RUN states.
REQ-013 SHALL have port done, output, 1: one-cycle expiry pulse.
REQ-014 SHALL have port err, output, 1: registered one-cycle pulse for a rejected start.

Function
REQ-015 SHALL sequence a free-running counter that increments every clock and loads cnt_data when cnt_load=1.
REQ-016 SHALL implement the FSM states IDLE, LOAD and RUN.
REQ-017 SHALL assert start_ack = start & IDLE & (period != 0), and SHALL capture period and periodic into internal registers on an acknowledged edge.
REQ-018 IDLE SHALL go to LOAD on an acknowledged start, and SHALL otherwise stay in IDLE with cnt_load=0 and cnt_data=0.
REQ-019 On start with period=0 in IDLE, the block SHALL stay in IDLE and pulse err in the next cycle.
REQ-020 In LOAD, the block SHALL drive cnt_load=1 and cnt_data=(0-N) mod 2^WIDTH, then go to RUN unconditionally.
REQ-021 In RUN, the block SHALL assert done = (count_in==0) & !stop.
REQ-022 With done in one-shot mode, the next state SHALL be IDLE.
REQ-023 With done in periodic mode, the block SHALL drive cnt_load=1 and cnt_data=(1-N) mod 2^WIDTH and stay in RUN.
REQ-024 First done SHALL occur in the cycle after the (N+1)th rising edge following the accepting edge; subsequent periodic done pulses SHALL be exactly N cycles apart.
REQ-025 N=1 periodic SHALL give done every cycle, and N=2^WIDTH-1 SHALL be supported without overflow.
REQ-026 stop in LOAD or RUN SHALL force IDLE at the next edge, and stop SHALL take priority over a same-cycle expiry (no done, no reload).
REQ-027 stop in IDLE SHALL have no effect, and start+stop together in IDLE SHALL accept the start.
REQ-028 start while busy SHALL be ignored (start_ack=0, no err), and the captured period/mode SHALL NOT change mid-run.
REQ-029 A change on period or periodic outside an acknowledged edge SHALL have no effect.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, period register=0, mode register=0, err=0.
REQ-031 Outputs SHALL therefore be cnt_load=0, cnt_data=0, busy=0, done=0 and start_ack=0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse, and operation SHALL resume on the first edge after rst deasserts.

Configuration
REQ-033 Macro INTERVAL_CTRL_EXPCNT_EN SHALL control an expiry counter.
REQ-034 With INTERVAL_CTRL_EXPCNT_EN defined: output exp_count[7:0] SHALL increment on each done, saturate at 255, clear on acknowledged start, and reset to 0.
REQ-035 Without INTERVAL_CTRL_EXPCNT_EN: no exp_count port and no associated logic.

Verification (WIDTH=5, counter instantiated alongside)
REQ-036 Scenario: start, period=4, periodic=0 -> cnt_data=28 in LOAD; done once, 5 edges after accept; busy falls the next cycle.
REQ-037 Scenario: start, period=3, periodic=1 -> done pulses 3 cycles apart for at least 5 pulses; reload value 30.
REQ-038 Scenario: stop two cycles into RUN with period=10 -> IDLE next edge; no done; busy=0.
REQ-039 Scenario: start with period=0 -> start_ack=0; err high for one cycle; state stays IDLE.
REQ-040 Scenario: start pulsed mid-run with period=7 -> ignored; original period=4 expiry timing unchanged.
REQ-041 Scenario: rst mid-run, then start with period=31, periodic=1 -> all outputs 0 during reset; done every 31 cycles afterwards; exp_count saturation at 255 checked when the macro is defined.

Source files
------------

// File: rtl/interval_ctrl_m.sv
// rtl/interval_ctrl_m.sv - interval sequencer that drives an external loadable up-counter
// Optional expiry counter output exp_count is built when INTERVAL_CTRL_EXPCNT_EN is defined.
module interval_ctrl_m #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  output logic             start_ack,
  output logic             busy,
  output logic             done,
`ifdef INTERVAL_CTRL_EXPCNT_EN
  output logic             err,
  output logic [7:0]       exp_count
`else
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    mode_d    = mode_q;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_data  = '0;
    start_ack = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        start_ack = start && (period != '0);
        err_d     = start && (period == '0);
        if (start_ack) begin
          state_d  = LOAD;
          period_d = period;
          mode_d   = periodic;
        end
      end
      LOAD: begin
        // Counter lands on -N so it reaches zero exactly N edges into RUN.
        cnt_load = 1'b1;
        cnt_data = '0 - period_q;
        state_d  = stop ? IDLE : RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (count_in == '0) begin
          done = 1'b1;
          if (mode_q) begin
            // Reload skips the zero already consumed by this expiry cycle.
            cnt_load = 1'b1;
            cnt_data = ONE - period_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err = err_q;

`ifdef INTERVAL_CTRL_EXPCNT_EN
  logic [7:0] exp_count_q, exp_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_count_q <= 8'd0;
    end else begin
      exp_count_q <= exp_count_d;
    end
  end

  always_comb begin
    exp_count_d = exp_count_q;
    if (start_ack) begin
      exp_count_d = 8'd0;
    end else if (done && (exp_count_q != 8'hff)) begin
      exp_count_d = exp_count_q + 8'd1;
    end
  end

  assign exp_count = exp_count_q;
`endif

endmodule

// File: tb/tb_interval_ctrl_m.sv
// tb/tb_interval_ctrl_m.sv - directed and random checks of interval_ctrl_m against a countdown model
// Exercises exp_count as well when INTERVAL_CTRL_EXPCNT_EN is defined.
module tb_interval_ctrl_m;
  localparam int W = 5;
  localparam int M = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stop, periodic;
  logic [W-1:0] period;
  logic [W-1:0] count_in;
  logic         cnt_load;
  logic [W-1:0] cnt_data;
  logic         start_ack, busy, done, err;
`ifdef INTERVAL_CTRL_EXPCNT_EN
  logic [7:0]   exp_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int obs_done[$];

  bit m_busy, m_load, m_per, m_err;
  int m_n, m_left, m_exp;

  interval_ctrl_m #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .period    (period),
    .count_in  (count_in),
    .cnt_load  (cnt_load),
    .cnt_data  (cnt_data),
    .start_ack (start_ack),
    .busy      (busy),
    .done      (done),
`ifdef INTERVAL_CTRL_EXPCNT_EN
    .err       (err),
    .exp_count (exp_count)
`else
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  // External free-running loadable counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_in <= '0;
    else if (cnt_load) count_in <= cnt_data;
    else count_in <= count_in + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_load = 0; m_per = 0; m_err = 0; m_n = 0; m_left = 0; m_exp = 0;
  endtask

  // One clock: drive inputs, check outputs mid-low-phase, advance model at the edge.
  task automatic step(input bit s, input bit sp, input bit per, input int n);
    bit e_ack, e_done, e_load, rej;
    int e_data;
    start = s; stop = sp; periodic = per; period = n[W-1:0];
    #2;
    e_ack  = s && !m_busy && (n != 0);
    e_done = m_busy && !m_load && (m_left == 0) && !sp;
    e_load = m_load || (e_done && m_per);
    e_data = m_load ? (M - m_n) % M : (e_done && m_per) ? (M + 1 - m_n) % M : 0;
    chk("start_ack", {31'd0, start_ack}, {31'd0, e_ack});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("cnt_load", {31'd0, cnt_load}, {31'd0, e_load});
    chk("cnt_data", {27'd0, cnt_data}, e_data);
`ifdef INTERVAL_CTRL_EXPCNT_EN
    chk("exp_count", {24'd0, exp_count}, m_exp);
`endif
    if (done === 1'b1) obs_done.push_back(cyc);
    rej = s && !m_busy && (n == 0);
    @(posedge clk);
    if (!m_busy) begin
      if (e_ack) begin
        m_busy = 1; m_load = 1; m_n = n; m_per = per; m_exp = 0;
      end
    end else if (sp) begin
      m_busy = 0; m_load = 0;
    end else if (m_load) begin
      m_load = 0; m_left = m_n;
    end else if (m_left == 0) begin
      if (m_exp < 255) m_exp++;
      if (m_per) m_left = m_n - 1;
      else m_busy = 0;
    end else begin
      m_left--;
    end
    m_err = rej;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask

  task automatic reset_check(input string tag);
    start = 0; stop = 0; periodic = 0; period = '0;
    rst = 1'b1;
    #2;
    chk({tag, "_cnt_load"}, {31'd0, cnt_load}, 0);
    chk({tag, "_cnt_data"}, {27'd0, cnt_data}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_start_ack"}, {31'd0, start_ack}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
`ifdef INTERVAL_CTRL_EXPCNT_EN
    chk({tag, "_exp_count"}, {24'd0, exp_count}, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cyc++;
  endtask

  initial begin
    int acc;
    rst = 1'b1; start = 0; stop = 0; periodic = 0; period = '0;
    model_clear();
    @(negedge clk);
    reset_check("reset");

    // One-shot N=4
    obs_done.delete();
    acc = cyc;
    step(1, 0, 0, 4);
    idle(9);
    chk("oneshot_count", obs_done.size(), 1);
    if (obs_done.size() > 0) chk("oneshot_latency", obs_done[0] - acc, 6);

    // Periodic N=3
    obs_done.delete();
    step(1, 0, 1, 3);
    idle(20);
    chk("per3_enough", obs_done.size() >= 5, 1);
    for (int i = 1; i < 5 && i < obs_done.size(); i++) chk("per3_gap", obs_done[i] - obs_done[i-1], 3);
    step(0, 1, 0, 0);
    idle(2);

    // Stop two cycles into RUN, N=10
    obs_done.delete();
    step(1, 0, 0, 10);
    idle(3);
    step(0, 1, 0, 0);
    idle(12);
    chk("stop_no_done", obs_done.size(), 0);

    // Rejected start
    step(1, 0, 0, 0);
    idle(2);

    // Start mid-run ignored
    obs_done.delete();
    acc = cyc;
    step(1, 0, 0, 4);
    idle(2);
    step(1, 0, 1, 7);
    idle(8);
    chk("midrun_count", obs_done.size(), 1);
    if (obs_done.size() > 0) chk("midrun_latency", obs_done[0] - acc, 6);

    // Reset mid-run, then N=31 periodic
    step(1, 0, 1, 6);
    idle(4);
    reset_check("midrst");
    obs_done.delete();
    step(1, 0, 1, 31);
    idle(130);
    chk("p31_enough", obs_done.size() >= 3, 1);
    for (int i = 1; i < obs_done.size(); i++) chk("p31_gap", obs_done[i] - obs_done[i-1], 31);
    step(0, 1, 0, 0);

`ifdef INTERVAL_CTRL_EXPCNT_EN
    step(1, 0, 1, 1);
    idle(270);
    chk("exp_sat", {24'd0, exp_count}, 255);
    step(0, 1, 0, 0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int n;
      n = ($urandom % 8 == 0) ? 0 : ($urandom % 4 == 0 ? 1 + $urandom % 3 : $urandom % 32);
      step(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom % 2, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
